// File: rtl/serial_tx_arbiter_if.sv
// Requester/transmitter bus for serial_tx_arbiter: byte streams in, serial_tx
// sequencing signals out, plus grant status.
interface serial_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_byte;
  logic                 tx_start;
  logic                 tx_done;
  logic                 grant_valid;
  logic [IDW-1:0]       grant_id;
  logic                 busy;
  logic                 err;

  // Environment side: requesters and the serial_tx transmitter.
  modport master (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, tx_byte, tx_start, grant_valid, grant_id, busy, err
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, tx_byte, tx_start, grant_valid, grant_id, busy, err
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one serial_tx among NUM_REQ requesters.
// Optional WAIT_DONE watchdog enabled by defining SERIAL_TX_ARBITER_TIMEOUT_EN.
module serial_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 2048
) (
  input logic                clk115,
  input logic                rst_n,
  serial_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, START, WAIT_DONE} state_t;

  state_t             state;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     grant_id_q;
  logic [IDW-1:0]     win_id;
  logic               win_found;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               last_q;
  logic               grant_valid_q;
  logic               busy_q;
  logic               tx_start_q;
  logic [7:0]         tx_byte_q;

  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << IDW) < NUM_REQ || TIMEOUT < 1 || TIMEOUT > 65536)
  begin : g_bad_params
    $error("serial_tx_arbiter: invalid parameter set");
  end

`ifdef SERIAL_TX_ARBITER_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        err_q;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Round-robin search: first valid requester starting just after rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!win_found && bus.req_valid[i] &&
            i == (32'(rr_ptr) + off) % 32'(NUM_REQ)) begin
          win_found = 1'b1;
          win_id    = IDW'(i);
        end
      end
    end
  end

  // Owner's stream and its pop strobe; only the granted bit can ever rise.
  always_comb begin
    sel_valid   = 1'b0;
    sel_last    = 1'b0;
    sel_data    = '0;
    req_ready_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == grant_id_q) begin
        sel_valid      = bus.req_valid[i];
        sel_last       = bus.req_last[i];
        sel_data       = bus.req_data[8*i +: 8];
        req_ready_c[i] = (state == FETCH) && bus.req_valid[i];
      end
    end
  end

  always_ff @(posedge clk115 or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= IDW'(NUM_REQ - 1);
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_byte_q     <= '0;
      last_q        <= 1'b0;
`ifdef SERIAL_TX_ARBITER_TIMEOUT_EN
      to_cnt        <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_id_q    <= win_id;
            grant_valid_q <= 1'b1;
            rr_ptr        <= win_id;
            busy_q        <= 1'b1;
            state         <= FETCH;
          end
        end
        FETCH: begin
          if (sel_valid) begin
            tx_byte_q  <= sel_data;
            last_q     <= sel_last;
            tx_start_q <= 1'b1;
            state      <= START;
          end
        end
        START: begin
`ifdef SERIAL_TX_ARBITER_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.tx_done) begin
            if (last_q) begin
              grant_valid_q <= 1'b0;
              busy_q        <= 1'b0;
              state         <= IDLE;
            end else begin
              state <= FETCH;
            end
          end
`ifdef SERIAL_TX_ARBITER_TIMEOUT_EN
          // rr_ptr already holds the owner, so the next search starts past it.
          else if (to_cnt == 16'(TIMEOUT - 1)) begin
            err_q         <= 1'b1;
            grant_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            state         <= IDLE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter with queued requester streams and a
// delayed-response serial_tx model.
module tb_serial_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
`ifdef SERIAL_TX_ARBITER_TIMEOUT_EN
  localparam int TMO = 64;
`else
  localparam int TMO = 2048;
`endif

  logic clk115 = 1'b0;
  logic rst_n  = 1'b0;
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;

  serial_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

  serial_tx_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW), .TIMEOUT(TMO)) dut (
    .clk115 (clk115),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk115 = ~clk115;
  initial forever begin @(posedge clk115); cyc++; end

  // Requester queues: {last, byte}
  logic [8:0] rq_mem  [NUM_REQ][32];
  int         rq_head [NUM_REQ];
  int         rq_tail [NUM_REQ];

  task automatic push(input int i, input logic [7:0] b, input logic l);
    rq_mem[i][rq_tail[i] % 32] = {l, b};
    rq_tail[i]++;
  endtask

  initial begin
    logic [NUM_REQ-1:0]   rdy;
    logic [NUM_REQ-1:0]   v;
    logic [NUM_REQ-1:0]   ls;
    logic [8*NUM_REQ-1:0] dat;
    logic [8:0]           ent;
    for (int i = 0; i < NUM_REQ; i++) begin rq_head[i] = 0; rq_tail[i] = 0; end
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
    forever begin
      @(negedge clk115); rdy = bus.req_ready;
      @(posedge clk115); #1;
      for (int i = 0; i < NUM_REQ; i++)
        if (rdy[i] && rq_head[i] != rq_tail[i]) rq_head[i]++;
      for (int i = 0; i < NUM_REQ; i++) begin
        v[i] = (rq_head[i] != rq_tail[i]);
        ent  = rq_mem[i][rq_head[i] % 32];
        dat[8*i +: 8] = v[i] ? ent[7:0] : 8'h00;
        ls[i] = v[i] & ent[8];
      end
      bus.req_valid = v; bus.req_data = dat; bus.req_last = ls;
    end
  end

  // serial_tx model: end_of_send model_delay cycles after each sbyte_rdy (0 = never).
  int   model_delay = 100;
  int   dly         = 0;
  logic model_done  = 1'b0;
  logic stray_done  = 1'b0;
  assign bus.tx_done = model_done | stray_done;

  initial forever begin
    @(posedge clk115); #2;
    model_done = 1'b0;
    if (!rst_n) dly = 0;
    else if (bus.tx_start && model_delay > 0) dly = model_delay;
    else if (dly > 0) begin dly--; if (dly == 0) model_done = 1'b1; end
  end

  // Transmission log and pop-strobe protocol watch.
  int         log_n = 0;
  logic [7:0] log_byte [128];
  int         log_id   [128];
  int         log_cyc  [128];
  int         done_n = 0;
  int         done_cyc [128];
  int         viol = 0;

  initial forever begin
    @(negedge clk115);
    if (rst_n) begin
      if (bus.tx_start && log_n < 128) begin
        log_byte[log_n] = bus.tx_byte; log_id[log_n] = int'(bus.grant_id);
        log_cyc[log_n] = cyc; log_n++;
      end
      if (bus.tx_done && done_n < 128) begin done_cyc[done_n] = cyc; done_n++; end
      if (bus.req_ready != '0 &&
          (!bus.grant_valid || bus.req_ready != (NUM_REQ'(1) << bus.grant_id))) viol++;
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk115);
    total++; if (bus.grant_valid !== 1'b0) $display("FAIL rst_grant_valid got %b want 0", bus.grant_valid); else passed++;
    total++; if (bus.grant_id !== 2'd0) $display("FAIL rst_grant_id got %0d want 0", bus.grant_id); else passed++;
    total++; if (bus.tx_byte !== 8'h00) $display("FAIL rst_tx_byte got %h want 00", bus.tx_byte); else passed++;
    total++; if (bus.tx_start !== 1'b0) $display("FAIL rst_tx_start got %b want 0", bus.tx_start); else passed++;
    total++; if (bus.req_ready !== 4'b0000) $display("FAIL rst_req_ready got %b want 0000", bus.req_ready); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy); else passed++;
    total++; if (bus.err !== 1'b0) $display("FAIL rst_err got %b want 0", bus.err); else passed++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk115);
    total++; if (bus.busy !== 1'b0) $display("FAIL idle_busy got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_single();
    int b, d, k, fall;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h48; exp_b[1] = 8'h69; exp_b[2] = 8'h0A;
    b = log_n; d = done_n; model_delay = 100;
    push(0, 8'h48, 1'b0); push(0, 8'h69, 1'b0); push(0, 8'h0A, 1'b1);
    for (k = 0; k < 20 && !bus.grant_valid; k++) @(negedge clk115);
    total++; if (bus.grant_valid !== 1'b1) $display("FAIL single_grant got %b want 1", bus.grant_valid); else passed++;
    total++; if (bus.grant_id !== 2'd0) $display("FAIL single_grant_id got %0d want 0", bus.grant_id); else passed++;
    total++; if (bus.req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", bus.req_ready); else passed++;
    total++; if (bus.tx_start !== 1'b0) $display("FAIL single_early_start got %b want 0", bus.tx_start); else passed++;
    @(negedge clk115);
    total++; if (bus.tx_start !== 1'b1) $display("FAIL single_start got %b want 1", bus.tx_start); else passed++;
    total++; if (bus.tx_byte !== 8'h48) $display("FAIL single_first_byte got %h want 48", bus.tx_byte); else passed++;
    total++; if (bus.req_ready !== 4'b0000) $display("FAIL single_ready_off got %b want 0000", bus.req_ready); else passed++;
    fall = -1;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk115);
      if (log_n >= b + 3 && !bus.grant_valid) begin fall = cyc; break; end
    end
    total++; if (log_n - b !== 3) $display("FAIL single_count got %0d want 3", log_n - b); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (log_byte[b+i] !== exp_b[i]) $display("FAIL single_byte%0d got %h want %h", i, log_byte[b+i], exp_b[i]); else passed++;
      total++; if (log_id[b+i] !== 0) $display("FAIL single_id%0d got %0d want 0", i, log_id[b+i]); else passed++;
    end
    total++; if (log_cyc[b+1] !== done_cyc[d] + 2) $display("FAIL single_gap got %0d want %0d", log_cyc[b+1], done_cyc[d] + 2); else passed++;
    total++; if (fall !== done_cyc[d+2] + 1) $display("FAIL single_release got %0d want %0d", fall, done_cyc[d+2] + 1); else passed++;
  endtask

  task automatic test_simultaneous();
    int b, k;
    int exp_id [4];
    logic [7:0] exp_b [4];
    exp_id[0] = 1; exp_id[1] = 2; exp_id[2] = 1; exp_id[3] = 2;
    exp_b[0] = 8'h11; exp_b[1] = 8'h21; exp_b[2] = 8'h12; exp_b[3] = 8'h22;
    b = log_n; model_delay = 5;
    push(1, 8'h11, 1'b1); push(2, 8'h21, 1'b1); push(1, 8'h12, 1'b1); push(2, 8'h22, 1'b1);
    for (k = 0; k < 500 && !(log_n >= b + 4 && !bus.busy); k++) @(negedge clk115);
    total++; if (log_n - b !== 4) $display("FAIL simul_count got %0d want 4", log_n - b); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (log_id[b+i] !== exp_id[i]) $display("FAIL simul_id%0d got %0d want %0d", i, log_id[b+i], exp_id[i]); else passed++;
      total++; if (log_byte[b+i] !== exp_b[i]) $display("FAIL simul_byte%0d got %h want %h", i, log_byte[b+i], exp_b[i]); else passed++;
    end
  endtask

  task automatic test_packet_lock();
    int b, k;
    b = log_n; model_delay = 20;
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
    for (k = 0; k < 500 && log_n < b + 2; k++) @(negedge clk115);
    push(3, 8'h3C, 1'b1);
    repeat (3) @(negedge clk115);
    total++; if (bus.req_valid[3] !== 1'b1 || bus.grant_id !== 2'd0) $display("FAIL lock_pending got valid3=%b id=%0d want 1/0", bus.req_valid[3], bus.grant_id); else passed++;
    for (k = 0; k < 1000 && !(log_n >= b + 5 && !bus.busy); k++) @(negedge clk115);
    total++; if (log_n - b !== 5) $display("FAIL lock_count got %0d want 5", log_n - b); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (log_id[b+i] !== 0 || log_byte[b+i] !== 8'hA0 + 8'(i)) $display("FAIL lock_byte%0d got id%0d %h want id0 %h", i, log_id[b+i], log_byte[b+i], 8'hA0 + 8'(i)); else passed++;
    end
    total++; if (log_id[b+4] !== 3 || log_byte[b+4] !== 8'h3C) $display("FAIL lock_next got id%0d %h want id3 3c", log_id[b+4], log_byte[b+4]); else passed++;
    total++; if (viol !== 0) $display("FAIL ready_protocol got %0d violations want 0", viol); else passed++;
  endtask

  task automatic test_fetch_stall();
    int b, d, k, starts, bad;
    b = log_n; d = done_n; model_delay = 10; starts = 0; bad = 0;
    push(0, 8'h55, 1'b0);
    for (k = 0; k < 200 && !(log_n >= b + 1 && done_n > d); k++) @(negedge clk115);
    for (k = 0; k < 50; k++) begin
      @(negedge clk115);
      stray_done = (k == 20);
      if (bus.tx_start) starts++;
      if (!bus.busy || !bus.grant_valid || bus.req_ready != '0) bad++;
    end
    stray_done = 1'b0;
    total++; if (starts !== 0) $display("FAIL stall_starts got %0d want 0", starts); else passed++;
    total++; if (bad !== 0) $display("FAIL stall_state got %0d bad cycles want 0", bad); else passed++;
    total++; if (bus.grant_id !== 2'd0) $display("FAIL stall_owner got %0d want 0", bus.grant_id); else passed++;
    push(0, 8'h56, 1'b1);
    for (k = 0; k < 200 && !(log_n >= b + 2 && !bus.busy); k++) @(negedge clk115);
    total++; if (log_n - b !== 2 || log_byte[b+1] !== 8'h56) $display("FAIL stall_resume got n=%0d %h want n=2 56", log_n - b, log_byte[b+1]); else passed++;
    @(negedge clk115); stray_done = 1'b1;
    @(negedge clk115); stray_done = 1'b0;
    @(negedge clk115);
    total++; if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0) $display("FAIL idle_stray got busy=%b start=%b want 0/0", bus.busy, bus.tx_start); else passed++;
  endtask

  task automatic test_reset_mid();
    int b, k;
    int exp_id [3];
    logic [7:0] exp_b [3];
    exp_id[0] = 0; exp_id[1] = 2; exp_id[2] = 3;
    exp_b[0] = 8'h90; exp_b[1] = 8'h92; exp_b[2] = 8'h93;
    b = log_n; model_delay = 30;
    push(0, 8'h70, 1'b0); push(0, 8'h71, 1'b0); push(0, 8'h72, 1'b1);
    for (k = 0; k < 300 && log_n < b + 2; k++) @(negedge clk115);
    repeat (3) @(negedge clk115);
    total++; if (bus.busy !== 1'b1) $display("FAIL mid_busy got %b want 1", bus.busy); else passed++;
    rst_n = 1'b0; #1;
    total++; if ({bus.grant_valid, bus.busy, bus.tx_start, bus.err} !== 4'b0000) $display("FAIL mid_rst_flags got %b want 0000", {bus.grant_valid, bus.busy, bus.tx_start, bus.err}); else passed++;
    total++; if (bus.tx_byte !== 8'h00 || bus.grant_id !== 2'd0 || bus.req_ready !== 4'b0000) $display("FAIL mid_rst_bus got %h %0d %b want 00 0 0000", bus.tx_byte, bus.grant_id, bus.req_ready); else passed++;
    rq_tail[0] = rq_head[0];
    repeat (2) @(negedge clk115);
    rst_n = 1'b1;
    b = log_n;
    push(0, 8'h90, 1'b1); push(2, 8'h92, 1'b1); push(3, 8'h93, 1'b1);
    for (k = 0; k < 500 && !(log_n >= b + 3 && !bus.busy); k++) @(negedge clk115);
    total++; if (log_n - b !== 3) $display("FAIL post_rst_count got %0d want 3", log_n - b); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (log_id[b+i] !== exp_id[i] || log_byte[b+i] !== exp_b[i]) $display("FAIL post_rst_order%0d got id%0d %h want id%0d %h", i, log_id[b+i], log_byte[b+i], exp_id[i], exp_b[i]); else passed++;
    end
  endtask

`ifdef SERIAL_TX_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    int b, k, seen;
    b = log_n; model_delay = 0;
    push(0, 8'h77, 1'b1); push(1, 8'h78, 1'b1);
    for (k = 0; k < 300 && !bus.err; k++) @(negedge clk115);
    seen = cyc;
    model_delay = 5;
    total++; if (bus.err !== 1'b1) $display("FAIL tmo_err got %b want 1", bus.err); else passed++;
    total++; if (bus.grant_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL tmo_release got gv=%b busy=%b want 0/0", bus.grant_valid, bus.busy); else passed++;
    total++; if (seen !== log_cyc[b] + TMO + 1) $display("FAIL tmo_latency got %0d want %0d", seen, log_cyc[b] + TMO + 1); else passed++;
    for (k = 0; k < 20 && !bus.grant_valid; k++) @(negedge clk115);
    total++; if (bus.grant_id !== 2'd1) $display("FAIL tmo_next_grant got %0d want 1", bus.grant_id); else passed++;
    for (k = 0; k < 200 && !(log_n >= b + 2 && !bus.busy); k++) @(negedge clk115);
    total++; if (log_byte[b+1] !== 8'h78 || bus.err !== 1'b1) $display("FAIL tmo_sticky got %h err=%b want 78 err=1", log_byte[b+1], bus.err); else passed++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_packet_lock();
    test_fetch_stall();
    test_reset_mid();
`ifdef SERIAL_TX_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
